// File: rtl/constant_pkg.sv
// Shared state encoding and word/byte helpers for the program sender.
package constant;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        LATCH,
        SEND,
        FIN
    } sender_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Little-endian byte lane of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return 8'(word >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/program_sender_uart_tx.sv
// 8N1 UART byte transmitter with registered txd; busy drops in the last stop-bit cycle
// so the next byte can follow without an idle gap.
module uart_tx_byte #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       txd
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int BAUD_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);

    logic              active;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [8:0]        shreg;
    logic              bit_end;
    logic              frame_end;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = bit_end && (bit_cnt == 4'd9);
    assign tx_busy   = active && !frame_end;

    // shreg carries the data bits followed by the stop bit, shifted out LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            txd      <= 1'b1;
        end else if (tx_start && !tx_busy) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= {1'b1, tx_data};
            txd      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/program_sender.sv
// Boot-loader link transmitter: sends a word-count header, then each word of a
// synchronous source memory, as little-endian bytes over UART.
module program_sender
    import constant::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic              busy,
    output logic              done,
    output logic              txd
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    sender_state_t state, next_state;

    logic [31:0] count;
    logic [31:0] words_sent;
    logic [31:0] shift_word;
    logic [1:0]  byte_idx;
    logic        byte_live;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;

    uart_tx_byte #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // byte_live marks that the current byte_idx has been handed to the transmitter;
    // tx_busy low while live means that byte is in its final stop-bit cycle.
    always_comb begin
        next_state = state;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            IDLE: if (start) next_state = HDR;
            HDR, SEND: begin
                if (!tx_busy) begin
                    if (!byte_live) begin
                        tx_start = 1'b1;
                        tx_data  = word_byte(shift_word, byte_idx);
                    end else if (byte_idx == LAST_IDX) begin
                        next_state = (words_sent == count) ? FIN : RD;
                    end else begin
                        tx_start = 1'b1;
                        tx_data  = word_byte(shift_word, byte_idx + 2'd1);
                    end
                end
            end
            RD:    next_state = LATCH;
            LATCH: begin
                tx_start   = 1'b1;
                tx_data    = mem_data[7:0];
                next_state = SEND;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            words_sent <= '0;
            shift_word <= '0;
            byte_idx   <= '0;
            byte_live  <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count      <= 32'(num_words);
                        shift_word <= 32'(num_words);
                        words_sent <= '0;
                        byte_idx   <= '0;
                        byte_live  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                HDR, SEND: begin
                    if (!tx_busy) begin
                        if (!byte_live) begin
                            byte_live <= 1'b1;
                        end else if (byte_idx == LAST_IDX) begin
                            byte_live <= 1'b0;
                            byte_idx  <= '0;
                            if (words_sent != count) mem_addr <= words_sent[ADDR_W-1:0];
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                LATCH: begin
                    shift_word <= mem_data;
                    words_sent <= words_sent + 32'd1;
                    byte_idx   <= '0;
                    byte_live  <= 1'b1;
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_sender.sv
// Directed bench for program_sender with a mid-bit sampling UART receiver model.
module tb_program_sender;

    localparam int HALF = 4;
    localparam int AW = 7;
    localparam int BYTE_CLKS = 20 * HALF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          busy;
    logic          done;
    logic          txd;

    logic [31:0] mem [0:(1<<AW)-1];

    int cyc = 0;
    int t0 = 0;
    int compared = 0;
    int mismatched = 0;

    logic [7:0] rx_data[$];
    int         rx_time[$];
    bit         rx_ferr[$];

    bit         rx_active = 1'b0;
    int         rx_k = 0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;
    bit         rx_serr = 1'b0;

    program_sender #(
        .CLK_PER_HALF_BIT(HALF),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_words(num_words),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) mem_data <= mem[mem_addr];

    // Receiver: start detected at k=0, samples at mid-bit (k = 4, 12..68, 76).
    always @(negedge clk) begin
        if (rst) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active <= 1'b1;
                rx_k      <= 1;
                rx_t      <= cyc;
                rx_serr   <= 1'b0;
            end
        end else begin
            rx_k <= rx_k + 1;
            if (rx_k == HALF && txd !== 1'b0) rx_serr <= 1'b1;
            if (rx_k >= 3 * HALF && rx_k <= 17 * HALF && ((rx_k - 3 * HALF) % (2 * HALF)) == 0)
                rx_sh <= {txd, rx_sh[7:1]};
            if (rx_k == 19 * HALF) begin
                rx_data.push_back(rx_sh);
                rx_time.push_back(rx_t);
                rx_ferr.push_back(rx_serr || (txd !== 1'b1));
                rx_active <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [AW:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        t0        = cyc;
        @(negedge clk);
        start     = 1'b0;
        num_words = '0;
    endtask

    task automatic clearRx();
        rx_data.delete();
        rx_time.delete();
        rx_ferr.delete();
    endtask

    task automatic waitTo(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic waitDone(input int limit, output int when, output bit timeout, output int max_addr);
        int n;
        n        = 0;
        timeout  = 1'b0;
        max_addr = int'(mem_addr);
        while (done !== 1'b1) begin
            if (n == limit) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
        when = cyc - t0;
    endtask

    task automatic checkStream(input string tag, input int nwords);
        int nbytes, lim, bad_data, bad_time, bad_frame;
        logic [31:0] w;
        logic [7:0]  eb;
        nbytes    = 4 * (nwords + 1);
        bad_data  = 0;
        bad_time  = 0;
        bad_frame = 0;
        checkOutput({tag, "_byte_count"}, 64'(rx_data.size()), 64'(nbytes));
        lim = (rx_data.size() < nbytes) ? rx_data.size() : nbytes;
        for (int k = 0; k < lim; k++) begin
            w  = (k < 4) ? 32'(nwords) : mem[k / 4 - 1];
            eb = 8'(w >> (8 * (k % 4)));
            if (rx_data[k] !== eb) bad_data++;
            if (rx_time[k] - t0 != 2 + BYTE_CLKS * k + 2 * (k / 4)) bad_time++;
            if (rx_ferr[k]) bad_frame++;
        end
        checkOutput({tag, "_bad_data"}, 64'(bad_data), 64'd0);
        checkOutput({tag, "_bad_timing"}, 64'(bad_time), 64'd0);
        checkOutput({tag, "_framing"}, 64'(bad_frame), 64'd0);
    endtask

    initial begin
        int when, maxa, extra;
        bit to, idle_bad;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_addr", mem_addr, 0);
        rst = 1'b0;
        idle_bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        end
        checkOutput("idle_quiet", idle_bad, 0);

        // Header only
        $display("[TB] zero-word transfer");
        clearRx();
        applyStimulus(0);
        checkOutput("zero_busy_rise", busy, 1);
        waitDone(2000, when, to, maxa);
        checkOutput("zero_timeout", to, 0);
        checkOutput("zero_done_time", 64'(when), 64'd323);
        checkOutput("zero_busy_fall", busy, 0);
        checkOutput("zero_addr_max", 64'(maxa), 64'd0);
        repeat (10) @(negedge clk);
        checkStream("zero", 0);

        // Two words
        $display("[TB] two-word transfer");
        mem[0] = 32'h12345678;
        mem[1] = 32'hDEADBEEF;
        clearRx();
        applyStimulus(2);
        waitDone(3000, when, to, maxa);
        checkOutput("two_timeout", to, 0);
        checkOutput("two_done_time", 64'(when), 64'd967);
        checkOutput("two_addr_max", 64'(maxa), 64'd1);
        repeat (10) @(negedge clk);
        checkStream("two", 2);
        checkOutput("two_byte0", rx_data[0], 8'h02);
        checkOutput("two_byte4", rx_data[4], 8'h78);
        checkOutput("two_byte11", rx_data[11], 8'hDE);
        checkOutput("two_byte4_start", 64'(rx_time[4] - t0), 64'd324);
        checkOutput("two_byte8_start", 64'(rx_time[8] - t0), 64'd646);

        // Second start during transfer
        $display("[TB] start while busy");
        clearRx();
        applyStimulus(2);
        waitTo(100);
        start = 1'b1;
        num_words = 8'd5;
        @(negedge clk);
        start = 1'b0;
        num_words = '0;
        waitDone(3000, when, to, maxa);
        checkOutput("busy_timeout", to, 0);
        checkOutput("busy_done_time", 64'(when), 64'd967);
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checkOutput("busy_extra_done", 64'(extra), 64'd0);
        checkStream("busy", 2);

        // Start in the FIN cycle
        $display("[TB] start during FIN");
        clearRx();
        applyStimulus(0);
        waitTo(322);
        checkOutput("fin_busy_held", busy, 1);
        start = 1'b1;
        num_words = 8'd3;
        @(negedge clk);
        start = 1'b0;
        num_words = '0;
        checkOutput("fin_done_pulse", done, 1);
        checkOutput("fin_busy_fall", busy, 0);
        @(negedge clk);
        checkOutput("fin_start_ignored", busy, 0);
        repeat (100) @(negedge clk);
        checkOutput("fin_rx_count", 64'(rx_data.size()), 64'd4);

        // Reset during data bits of byte 5
        $display("[TB] reset mid-frame");
        clearRx();
        applyStimulus(2);
        waitTo(414);
        checkOutput("rst_pre_txd", txd, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_txd", txd, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("rst_rx_count", 64'(rx_data.size()), 64'd5);
        checkOutput("rst_stay_idle", {busy, txd}, 2'b01);
        clearRx();
        applyStimulus(1);
        waitDone(2000, when, to, maxa);
        checkOutput("restart_timeout", to, 0);
        checkOutput("restart_done_time", 64'(when), 64'd645);
        repeat (10) @(negedge clk);
        checkStream("restart", 1);
        checkOutput("restart_byte0", rx_data[0], 8'h01);

        // 64 random words
        $display("[TB] 64 random words");
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        clearRx();
        applyStimulus(64);
        waitDone(30000, when, to, maxa);
        checkOutput("rand_timeout", to, 0);
        checkOutput("rand_done_time", 64'(when), 64'd20931);
        checkOutput("rand_addr_max", 64'(maxa), 64'd63);
        repeat (10) @(negedge clk);
        checkStream("rand", 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
